// File: rtl/capture_pkg.sv
// Shared constants for the capture datapath: word width and statistics counter width.
package capture_pkg;
    localparam int CAP_WORD_W = 64;
    localparam int STAT_W     = 32;

    typedef logic [STAT_W-1:0] stat_t;
endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM with one write port, one registered read port and a single clock.
module sdp_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/capture_pkt_fifo.sv
// Store-and-forward packet FIFO: packets become readable only once their last beat is
// committed; packets that do not fit are dropped whole and counted.
module capture_pkt_fifo
    import capture_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = CAP_WORD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic [WIDTH-1:0]       m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    input  logic                   clr_stats,
    output logic [STAT_W-1:0]      pkt_count,
    output logic [STAT_W-1:0]      drop_count,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    function automatic stat_t sat_inc(input stat_t v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    logic [PW-1:0]  wr_ptr, wr_commit, rd_fetch, rd_ptr;
    logic           drop_q;
    logic           accept, full, dropping, wr_en, commit, drop_done;
    logic           pop, rd_en, vld_p1, skid_vld;
    logic [1:0]     occ;
    logic [WIDTH:0] rd_data_p1, skid_data;

    // rd_ptr only advances on output handshakes, so words still held in the
    // output/skid registers keep their memory slot reserved and stay in level.
    assign accept    = s_tvalid && s_tready;
    assign full      = ((wr_ptr - rd_ptr) == PW'(DEPTH));
    assign dropping  = drop_q || full;
    assign wr_en     = accept && !dropping;
    assign commit    = wr_en && s_tlast;
    assign drop_done = accept && dropping && s_tlast;
    assign level     = wr_commit - rd_ptr;

    // ---- write / commit stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_tready  <= 1'b0;
            wr_ptr    <= '0;
            wr_commit <= '0;
            drop_q    <= 1'b0;
        end else begin
            s_tready <= 1'b1;
            if (accept) begin
                if (dropping) begin
                    if (s_tlast) begin
                        wr_ptr <= wr_commit;
                        drop_q <= 1'b0;
                    end else begin
                        drop_q <= 1'b1;
                    end
                end else begin
                    wr_ptr <= wr_ptr + PW'(1);
                    if (s_tlast) begin
                        wr_commit <= wr_ptr + PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (clr_stats) begin
                pkt_count <= '0;
            end else if (commit) begin
                pkt_count <= sat_inc(pkt_count);
            end
            if (clr_stats) begin
                drop_count <= '0;
            end else if (drop_done) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({s_tlast, s_tdata}),
        .rd_en   (rd_en),
        .rd_addr (rd_fetch[AW-1:0]),
        .rd_data (rd_data_p1)
    );

    // ---- fetch stage (p0 -> p1): two output slots, so fetch only while one will be free ----
    assign pop   = m_tvalid && m_tready;
    assign occ   = 2'(m_tvalid) + 2'(skid_vld) + 2'(vld_p1);
    assign rd_en = (rd_fetch != wr_commit) && ((occ - 2'(pop)) < 2'd2);

    // ---- output stage (p1 -> p2): skid holds a returning word while the output stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_fetch  <= '0;
            rd_ptr    <= '0;
            vld_p1    <= 1'b0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            m_tdata   <= '0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                rd_fetch <= rd_fetch + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (!m_tvalid || m_tready) begin
                if (skid_vld) begin
                    {m_tlast, m_tdata} <= skid_data;
                    m_tvalid           <= 1'b1;
                    skid_vld           <= vld_p1;
                    if (vld_p1) begin
                        skid_data <= rd_data_p1;
                    end
                end else if (vld_p1) begin
                    {m_tlast, m_tdata} <= rd_data_p1;
                    m_tvalid           <= 1'b1;
                end else begin
                    m_tvalid <= 1'b0;
                end
            end else if (vld_p1) begin
                skid_vld  <= 1'b1;
                skid_data <= rd_data_p1;
            end
        end
    end
endmodule

// File: tb/tb_capture_pkt_fifo.sv
// Scoreboard bench for capture_pkt_fifo at DEPTH = 64: expected beats are queued as
// packets are driven and compared as the output stream hands them over.
module tb_capture_pkt_fifo;
    localparam int DEPTH = 64;
    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] s_tdata = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tlast = 1'b0;
    logic             s_tready;
    logic [WIDTH-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready = 1'b0;
    logic             clr_stats = 1'b0;
    logic [31:0]      pkt_count;
    logic [31:0]      drop_count;
    logic [6:0]       level;

    capture_pkt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .clr_stats  (clr_stats),
        .pkt_count  (pkt_count),
        .drop_count (drop_count),
        .level      (level)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          recv = 0;
    int          sent_w = 0;
    int          last_acc_cyc = 0;
    bit          rdy_rand = 1'b0;
    bit          rdy_fixed = 1'b1;
    logic [64:0] exp_q[$];
    bit          hold_pend = 1'b0;
    logic [64:0] held = '0;

    task automatic chk_val(input string tag, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Output monitor: scoreboard compare on handshake, stability check while stalled.
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk_val("hold_vld", m_tvalid, 1'b1);
                chk_val("hold_dat", {m_tlast, m_tdata}, held);
            end
            if (m_tvalid && m_tready) begin
                recv++;
                if (exp_q.size() == 0) begin
                    chk_val("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk_val("beat", {m_tlast, m_tdata}, e);
                end
            end
            hold_pend = m_tvalid && !m_tready;
            held      = {m_tlast, m_tdata};
        end
    end

    task automatic send_pkt(input int len, input logic [63:0] base, input bit pass,
                            input bit clr_last);
        for (int i = 0; i < len; i++) begin
            s_tvalid  = 1'b1;
            s_tdata   = base + 64'(i);
            s_tlast   = (i == len - 1);
            clr_stats = clr_last && (i == len - 1);
            if (pass) exp_q.push_back({s_tlast, s_tdata});
            sent_w++;
            @(posedge clk);
            #1;
        end
        last_acc_cyc = cyc;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        step(1);
        clr_stats = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step(1);
            n++;
        end
        chk_val("drained", exp_q.size(), 0);
        step(4);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int rbase;
        int n;
        int len;
        int occ;

        // Reset state
        step(2);
        chk_val("rst_s_tready", s_tready, 0);
        chk_val("rst_m_tvalid", m_tvalid, 0);
        chk_val("rst_m_tdata", m_tdata, 0);
        chk_val("rst_m_tlast", m_tlast, 0);
        chk_val("rst_level", level, 0);
        chk_val("rst_pkt", pkt_count, 0);
        chk_val("rst_drop", drop_count, 0);
        rst_n = 1'b1;
        step(1);
        chk_val("s_tready_up", s_tready, 1);
        step(2);

        // 51-word packet, m_tready = 1
        rbase = recv;
        send_pkt(51, 64'hA000_0000_0000_0000, 1'b1, 1'b0);
        n = 0;
        while (!m_tvalid && n < 10) begin
            step(1);
            n++;
        end
        chk_val("first_lat", cyc - last_acc_cyc, 2);
        drain(200);
        chk_val("n51_beats", recv - rbase, 51);
        chk_val("n51_pkt", pkt_count, 1);

        // Two 40-word packets while stalled: second one dropped
        rdy_fixed = 1'b0;
        step(2);
        send_pkt(40, 64'hB000_0000_0000_0000, 1'b1, 1'b0);
        send_pkt(40, 64'hC000_0000_0000_0000, 1'b0, 1'b0);
        step(4);
        chk_val("stall_level", level, 40);
        chk_val("stall_drop", drop_count, 1);
        chk_val("stall_pkt", pkt_count, 2);
        rbase = recv;
        rdy_fixed = 1'b1;
        drain(200);
        chk_val("stall_drain_n", recv - rbase, 40);
        chk_val("stall_drain_lvl", level, 0);

        // Oversized packet dropped, next short packet intact
        pulse_clr();
        chk_val("clr_pkt", pkt_count, 0);
        chk_val("clr_drop", drop_count, 0);
        send_pkt(100, 64'hD000_0000_0000_0000, 1'b0, 1'b0);
        step(4);
        chk_val("big_level", level, 0);
        chk_val("big_drop", drop_count, 1);
        chk_val("big_pkt", pkt_count, 0);
        send_pkt(3, 64'hE000_0000_0000_0000, 1'b1, 1'b0);
        drain(50);
        chk_val("after_big_pkt", pkt_count, 1);

        // 200 random packets under random back-pressure
        pulse_clr();
        rdy_rand = 1'b1;
        rbase = recv;
        sent_w = 0;
        for (int p = 0; p < 200; p++) begin
            len = $urandom_range(1, 8);
            n = 0;
            occ = sent_w - (recv - rbase);
            while (occ + len > DEPTH - 4 && n < 2000) begin
                step(1);
                n++;
                occ = sent_w - (recv - rbase);
            end
            if (n >= 2000) chk_val("flow_timeout", n, 0);
            send_pkt(len, {$urandom, $urandom}, 1'b1, 1'b0);
        end
        drain(3000);
        chk_val("rnd_pkt", pkt_count, 200);
        chk_val("rnd_drop", drop_count, 0);
        chk_val("rnd_beats", recv - rbase, sent_w);
        rdy_rand = 1'b0;
        rdy_fixed = 1'b1;
        step(2);

        // Reset mid-packet
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'hF000_0000_0000_0000 + 64'(i);
            s_tlast  = 1'b0;
            step(1);
        end
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        #1;
        chk_val("mid_rst_s_tready", s_tready, 0);
        chk_val("mid_rst_m_tvalid", m_tvalid, 0);
        chk_val("mid_rst_pkt", pkt_count, 0);
        step(3);
        chk_val("mid_rst_level", level, 0);
        chk_val("mid_rst_m_tdata", m_tdata, 0);
        chk_val("mid_rst_drop", drop_count, 0);
        rst_n = 1'b1;
        step(1);
        chk_val("rerun_s_tready", s_tready, 1);
        send_pkt(4, 64'h1234_0000_0000_0000, 1'b1, 1'b0);
        drain(50);
        chk_val("rerun_pkt", pkt_count, 1);

        // clr_stats together with a commit; then a single-beat packet
        send_pkt(2, 64'h5555_0000_0000_0000, 1'b1, 1'b1);
        chk_val("clr_commit_pkt", pkt_count, 0);
        drain(50);
        send_pkt(1, 64'h7777_0000_0000_0000, 1'b1, 1'b0);
        drain(50);
        chk_val("single_pkt", pkt_count, 1);
        chk_val("final_level", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/capture_pkt_fifo.md
CAPTURE_PKT_FIFO -- requirements
Module: capture_pkt_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning FIFO capacity in 64-bit words (power of two, >= 64).
REQ-002 SHALL have parameter WIDTH, default 64, meaning data word width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports s_tdata  input  WIDTH, s_tvalid  input  1, s_tlast  input  1, s_tready  output  1: packet stream from the capture packetizer.
REQ-006 SHALL have ports m_tdata  output  WIDTH, m_tvalid  output  1, m_tlast  output  1, m_tready  input  1: packet stream to the readout path.
REQ-007 SHALL have port clr_stats  input  1  synchronous clear of the statistics counters.
REQ-008 SHALL have ports pkt_count  output  32, drop_count  output  32, level  output  $clog2(DEPTH)+1: statistics and the count of stored words.

Function
REQ-009 SHALL operate store-and-forward: no beat of a packet appears on m_* until that packet's s_tlast beat is committed.
REQ-010 SHALL hold s_tready = 1 at all times after reset; the source is never back-pressured, and overflow is handled by dropping packets.
REQ-011 SHALL store each accepted beat as {tlast, tdata} at wr_ptr and then increment wr_ptr.
REQ-012 SHALL keep a committed pointer wr_commit; commit sets wr_commit = wr_ptr + 1 on an accepted, non-dropped tlast beat.
REQ-013 SHALL set a drop flag when a beat arrives while stored words (wr_ptr - rd_ptr) == DEPTH; that beat and the rest of its packet are discarded.
REQ-014 SHALL, on the tlast beat of a dropped packet, rewind wr_ptr to wr_commit, clear the drop flag and increment drop_count.
REQ-015 SHALL drop any packet longer than DEPTH words without corrupting previously committed packets.
REQ-016 SHALL read only while rd_ptr != wr_commit, so uncommitted words are never read.
REQ-017 SHALL have one-cycle read latency from the memory and use a prefetch register plus a one-entry skid, so m_tvalid can stay high with m_tready = 1 for back-to-back beats.
REQ-018 SHALL make the first beat of a committed packet valid on m_tvalid exactly 2 cycles after the cycle its tlast beat is accepted, when the output path is empty.
REQ-019 SHALL hold m_tdata and m_tlast stable while m_tvalid = 1 and m_tready = 0.
REQ-020 SHALL increment pkt_count once per committed packet; pkt_count and drop_count saturate at 2^32-1.
REQ-021 SHALL give clr_stats priority over a same-cycle increment, so the counter reads 0 on the next cycle.
REQ-022 SHALL use pointers of $clog2(DEPTH)+1 bits that wrap modulo 2*DEPTH; full and empty are distinguished by the MSB.
REQ-023 SHALL report level = wr_commit - rd_ptr, counting committed, unread words only.
REQ-024 SHALL handle a commit and a read in the same cycle independently, with neither lost.
REQ-025 SHALL accept a single-beat packet (s_tlast on the first beat) as a normal packet.

Reset
REQ-026 SHALL, while rst_n = 0, asynchronously clear wr_ptr, wr_commit, rd_ptr, the drop flag, prefetch/skid valids, m_tvalid, m_tlast, m_tdata, pkt_count, drop_count and level to 0.
REQ-027 SHALL, while rst_n = 0, drive s_tready to 0; s_tready goes to 1 on the first clk edge after rst_n deasserts.
REQ-028 SHALL discard any packet partially written when reset asserts; memory contents need no reset.

Structure
REQ-029 SHALL place CAP_WORD_W (64) and the statistics counter width (32) in the shared package capture_pkg.
REQ-030 SHALL implement storage in one sub-module, sdp_ram: simple dual-port, WIDTH+1 bits x DEPTH, registered read, one write port and one read port on clk.

Verification
REQ-031 SHALL cover: a 51-word packet with m_tready = 1 -> 51 beats out in order, tlast only on beat 51, first beat 2 cycles after input tlast, pkt_count = 1.
REQ-032 SHALL cover: DEPTH = 64, m_tready = 0, two 40-word packets -> first stored (level = 40), second dropped, drop_count = 1; with m_tready = 1, exactly 40 words drain.
REQ-033 SHALL cover: a 100-word packet into DEPTH = 64 -> dropped, level = 0, drop_count = 1; a following 3-word packet passes intact.
REQ-034 SHALL cover: random m_tready (50%) with 200 back-to-back 1..8-word packets -> output stream equals input, no lost or duplicated beat, and data stable while stalled.
REQ-035 SHALL cover: rst_n pulsed low mid-packet -> all outputs 0 during reset; after release, the next packet passes and no fragment of the old one appears.
REQ-036 SHALL cover: clr_stats asserted in the same cycle as a commit -> pkt_count = 0 on the next cycle, and the packet is still delivered.
